branch_pred_ctrl: RTL
=====================

Name: branch_pred_ctrl

Overview:
- Branch prediction and misprediction-recovery controller for the RISC-V pipeline.
- Supplies a taken/not-taken prediction to fetch from a table of 2-bit saturating counters (BHT).
- Consumes the resolved branch flag from the EX-stage branch-condition comparator, updates the BHT, and sequences flush/redirect on mispredicts.
- Keeps branch and mispredict statistics counters.

Parameters:
BITS, 32, datapath/PC width
BHT_IDX_W, 6, BHT index width; table holds 2^BHT_IDX_W entries
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
IF_PC  input  BITS  fetch-stage PC used for BHT lookup
IF_IS_BRANCH  input  1  fetch predecode: instruction is a conditional branch
PRED_TAKEN  output  1  prediction to fetch; 0 when IF_IS_BRANCH=0
EX_VALID  input  1  EX stage holds a valid instruction
EX_IS_BRANCH  input  1  EX instruction is a conditional branch
EX_PC  input  BITS  PC of EX instruction
EX_PRED_TAKEN  input  1  prediction carried down the pipe with the EX instruction
EX_BRANCH  input  1  resolved outcome from the branch-condition comparator
EX_TARGET  input  BITS  computed branch target
STALL  input  1  pipeline stall; EX contents are not final this cycle
FLUSH  output  1  squash IF/ID and ID/EX contents
REDIRECT_VALID  output  1  fetch must load REDIRECT_PC
REDIRECT_PC  output  BITS  corrected fetch address
BR_CNT  output  CNT_W  number of resolved branches
MISPRED_CNT  output  CNT_W  number of mispredicted branches

Behaviour:
- Reset is synchronous on the clk edge with rst=1:
  - FSM enters IDLE.
  - All BHT entries are set to 2'b01 (weakly not-taken).
  - FLUSH=0, REDIRECT_VALID=0, REDIRECT_PC=0, BR_CNT=0, MISPRED_CNT=0.
  - Reset asserted mid-recovery aborts the recovery immediately; no FLUSH on the following cycle.
- Indexing: idx = PC[BHT_IDX_W+1:2]. PC[1:0] are ignored.
- Lookup is combinational from registered table state:
  - PRED_TAKEN = IF_IS_BRANCH & BHT[idx(IF_PC)][1].
- Resolve condition (one cycle): res = EX_VALID & EX_IS_BRANCH & ~STALL & (state==IDLE).
  - mis = res & (EX_BRANCH != EX_PRED_TAKEN).
- BHT update, applied on the clk edge when res=1, at idx(EX_PC):
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
  - Lookup and update to the same index in the same cycle: PRED_TAKEN reflects the pre-update value. There is no bypass.
- Statistics counters:
  - BR_CNT increments on res; MISPRED_CNT increments on mis.
  - Both saturate at all-ones and never wrap.
- FSM has three states:
  - IDLE: if mis, latch REDIRECT_PC = EX_BRANCH ? EX_TARGET : EX_PC+4 (modulo 2^BITS) and go to RECOVER. Otherwise stay in IDLE.
  - RECOVER: FLUSH=1 and REDIRECT_VALID=1 for exactly this one cycle. Go to DRAIN unconditionally; STALL is ignored here because the flush overrides the stall.
  - DRAIN: FLUSH=1, REDIRECT_VALID=0. EX inputs are ignored because they are wrong-path. Return to IDLE next cycle.
- Timing:
  - Mispredict-to-redirect latency is 1 cycle after the resolving edge.
  - Total recovery window is 2 cycles.
  - No branch resolves while in RECOVER or DRAIN.
- FLUSH and REDIRECT_VALID are registered state decodes and are glitch-free.
- REDIRECT_PC holds its last value outside RECOVER.
- Correctly predicted branches cause no FLUSH and no FSM transition.
- A non-branch instruction, or EX_VALID=0, leaves the BHT and counters unchanged.
- STALL=1 in IDLE: no update, no count, no transition. The same branch resolves once when STALL drops.

Test Plan:
- Reset, then IF_PC=0x100, IF_IS_BRANCH=1 -> PRED_TAKEN=0. Present EX_PC=0x100 taken twice (EX_PRED_TAKEN=0, then 1) -> BHT entry 10 then 11, and PRED_TAKEN=1 after the first update.
- Mispredict: EX_PC=0x200, EX_PRED_TAKEN=0, EX_BRANCH=1, EX_TARGET=0x340 -> next cycle REDIRECT_VALID=1, FLUSH=1, REDIRECT_PC=0x340; following cycle FLUSH=1 only; then IDLE. MISPRED_CNT=1, BR_CNT=1.
- Mispredict not-taken: EX_PC=0xFFFFFFFC, predicted taken, actual not taken -> REDIRECT_PC=0x00000000 (wrap).
- STALL held 3 cycles with a mispredicted branch in EX -> no FLUSH and no count during the stall; exactly one recovery after STALL drops. Branch presented during DRAIN is ignored (BR_CNT unchanged).
- Saturation: 5 not-taken updates on one index -> counter stays 00. Same-cycle lookup/update of that index returns the old bit.
- rst asserted during RECOVER -> next cycle FLUSH=0, REDIRECT_VALID=0, counters 0, all BHT entries 01.

Source files
------------

// File: rtl/branch_pred_ctrl.sv
// Branch predictor (2-bit saturating BHT) with misprediction flush/redirect sequencing
// and branch/mispredict statistics counters.
module branch_pred_ctrl #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BITS-1:0]  IF_PC,
  input  logic             IF_IS_BRANCH,
  output logic             PRED_TAKEN,
  input  logic             EX_VALID,
  input  logic             EX_IS_BRANCH,
  input  logic [BITS-1:0]  EX_PC,
  input  logic             EX_PRED_TAKEN,
  input  logic             EX_BRANCH,
  input  logic [BITS-1:0]  EX_TARGET,
  input  logic             STALL,
  output logic             FLUSH,
  output logic             REDIRECT_VALID,
  output logic [BITS-1:0]  REDIRECT_PC,
  output logic [CNT_W-1:0] BR_CNT,
  output logic [CNT_W-1:0] MISPRED_CNT
);

  localparam int unsigned BHT_DEPTH = 1 << BHT_IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOVER = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   flush_d;
  logic                   redirect_valid_d;
  logic                   res;
  logic                   mis;
  logic [BITS-1:0]        fix_pc;
  logic [1:0]             bht_q [BHT_DEPTH];
  logic [BHT_IDX_W-1:0]   if_idx;
  logic [BHT_IDX_W-1:0]   ex_idx;
  logic                   unused_if_pc;

  assign if_idx       = IF_PC[BHT_IDX_W+1:2];
  assign ex_idx       = EX_PC[BHT_IDX_W+1:2];
  assign unused_if_pc = ^{IF_PC[BITS-1:BHT_IDX_W+2], IF_PC[1:0]};

  // Lookup reads registered table state only, so a same-cycle update is not visible.
  assign PRED_TAKEN = IF_IS_BRANCH & bht_q[if_idx][1];

  // Next-state and registered-output decode.
  always_comb begin
    state_d          = state_q;
    res              = 1'b0;
    mis              = 1'b0;
    fix_pc           = EX_BRANCH ? EX_TARGET : EX_PC + BITS'(4);
    unique case (state_q)
      IDLE: begin
        res = EX_VALID & EX_IS_BRANCH & ~STALL;
        mis = res & (EX_BRANCH != EX_PRED_TAKEN);
        if (mis) begin
          state_d = RECOVER;
        end
      end
      RECOVER: state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    flush_d          = (state_d != IDLE);
    redirect_valid_d = (state_d == RECOVER);
  end

  // State, recovery outputs and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      FLUSH          <= 1'b0;
      REDIRECT_VALID <= 1'b0;
      REDIRECT_PC    <= '0;
      BR_CNT         <= '0;
      MISPRED_CNT    <= '0;
    end else begin
      state_q        <= state_d;
      FLUSH          <= flush_d;
      REDIRECT_VALID <= redirect_valid_d;
      if (mis) begin
        REDIRECT_PC <= fix_pc;
      end
      if (res && !(&BR_CNT)) begin
        BR_CNT <= BR_CNT + CNT_W'(1);
      end
      if (mis && !(&MISPRED_CNT)) begin
        MISPRED_CNT <= MISPRED_CNT + CNT_W'(1);
      end
    end
  end

  // Saturating 2-bit counter update at the resolving branch's index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (res) begin
      if (EX_BRANCH && (bht_q[ex_idx] != 2'b11)) begin
        bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
      end else if (!EX_BRANCH && (bht_q[ex_idx] != 2'b00)) begin
        bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
      end
    end
  end

endmodule
